// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared constants and access-conflict rule for sram_arbiter
package sram_arbiter_pkg;

  localparam int IDW = 4;

  // Same address with at least one write; two reads of one word may share a cycle
  function automatic logic is_conflict(input logic same_addr, input logic wr_a, input logic wr_b);
    return same_addr & (wr_a | wr_b);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - cyclic first-set-bit finder starting at a given index
module rr_pick
  import sram_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [IDW-1:0] start_i,
  input  logic [N-1:0]   mask_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  always_comb begin
    // Rotate so that the start index lands on bit 0, then take the lowest set bit
    rot     = N'({mask_i, mask_i} >> start_i);
    found_o = 1'b0;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        off     = IDW'(k);
      end
    end
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (IDW + 1)'(N)) begin
      sum = sum - (IDW + 1)'(N);
    end
    idx_o = sum[IDW-1:0];
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter mapping nreq requesters onto a dual-port SRAM
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int nreq   = 4,
  parameter int nbits  = 8,
  parameter int nwords = 8,
  parameter int naddrb = $clog2(nwords)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [nreq-1:0]        req_valid,
  input  logic [nreq-1:0]        req_wr,
  input  logic [nreq*naddrb-1:0] req_addr,
  input  logic [nreq*nbits-1:0]  req_data,
  output logic [nreq-1:0]        req_grant,
  output logic [nreq-1:0]        rsp_valid,
  output logic [nreq*nbits-1:0]  rsp_data,
  output logic                   mem_rden_1,
  output logic                   mem_wren_1,
  output logic [naddrb-1:0]      mem_addr_1,
  output logic [nbits-1:0]       mem_data_1,
  input  logic [nbits-1:0]       mem_q_1,
  output logic                   mem_rden_2,
  output logic                   mem_wren_2,
  output logic [naddrb-1:0]      mem_addr_2,
  output logic [nbits-1:0]       mem_data_2,
  input  logic [nbits-1:0]       mem_q_2
);

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]        pend_q, pend_d;
  logic [IDW-1:0]    id1_q, id1_d, id2_q, id2_d;

  logic              found1, found2, g1, g2, wr1, wr2;
  logic [IDW-1:0]    win1, win2, start2;
  logic [nreq-1:0]   mask2;
  logic [naddrb-1:0] addr1, addr2;
  logic [nbits-1:0]  data1, data2;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == IDW'(nreq - 1)) ? '0 : v + IDW'(1);
  endfunction

  rr_pick #(.N(nreq)) u_pick1 (
    .start_i (rr_ptr_q),
    .mask_i  (req_valid),
    .found_o (found1),
    .idx_o   (win1)
  );

  always_comb begin
    wr1   = 1'b0;
    addr1 = '0;
    data1 = '0;
    for (int i = 0; i < nreq; i++) begin
      if (win1 == IDW'(i)) begin
        wr1   = req_wr[i];
        addr1 = req_addr[i*naddrb +: naddrb];
        data1 = req_data[i*nbits +: nbits];
      end
    end
  end

  // Port 2 may take anyone except the port-1 winner and requests that collide with it
  always_comb begin
    mask2 = '0;
    for (int i = 0; i < nreq; i++) begin
      mask2[i] = req_valid[i] && (win1 != IDW'(i)) &&
                 !is_conflict(req_addr[i*naddrb +: naddrb] == addr1, req_wr[i], wr1);
    end
  end

  assign start2 = wrap_inc(win1);

  rr_pick #(.N(nreq)) u_pick2 (
    .start_i (start2),
    .mask_i  (mask2),
    .found_o (found2),
    .idx_o   (win2)
  );

  always_comb begin
    wr2   = 1'b0;
    addr2 = '0;
    data2 = '0;
    for (int i = 0; i < nreq; i++) begin
      if (win2 == IDW'(i)) begin
        wr2   = req_wr[i];
        addr2 = req_addr[i*naddrb +: naddrb];
        data2 = req_data[i*nbits +: nbits];
      end
    end
  end

  assign g1 = found1 & ~rst;
  assign g2 = found2 & ~rst;

  always_comb begin
    req_grant = '0;
    for (int i = 0; i < nreq; i++) begin
      req_grant[i] = (g1 && (win1 == IDW'(i))) || (g2 && (win2 == IDW'(i)));
    end
  end

  assign mem_rden_1 = g1 & ~wr1;
  assign mem_wren_1 = g1 & wr1;
  assign mem_addr_1 = g1 ? addr1 : '0;
  assign mem_data_1 = g1 ? data1 : '0;
  assign mem_rden_2 = g2 & ~wr2;
  assign mem_wren_2 = g2 & wr2;
  assign mem_addr_2 = g2 ? addr2 : '0;
  assign mem_data_2 = g2 ? data2 : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (g2) begin
      rr_ptr_d = wrap_inc(win2);
    end else if (g1) begin
      rr_ptr_d = wrap_inc(win1);
    end
    pend_d = {mem_rden_2, mem_rden_1};
    id1_d  = pend_d[0] ? win1 : '0;
    id2_d  = pend_d[1] ? win2 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      pend_q   <= '0;
      id1_q    <= '0;
      id2_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= pend_d;
      id1_q    <= id1_d;
      id2_q    <= id2_d;
    end
  end

  // SRAM read data arrives one cycle after the grant; route it back to the recorded id
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < nreq; i++) begin
      if (!rst && pend_q[0] && (id1_q == IDW'(i))) begin
        rsp_valid[i]              = 1'b1;
        rsp_data[i*nbits +: nbits] = mem_q_1;
      end
      if (!rst && pend_q[1] && (id2_q == IDW'(i))) begin
        rsp_valid[i]              = 1'b1;
        rsp_data[i*nbits +: nbits] = mem_q_2;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM and reference model
module tb_sram_arbiter;

  localparam int N  = 4;
  localparam int NB = 8;
  localparam int NW = 8;
  localparam int AB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_wr, req_grant, rsp_valid;
  logic [N*AB-1:0] req_addr;
  logic [N*NB-1:0] req_data, rsp_data;
  logic          mem_rden_1, mem_wren_1, mem_rden_2, mem_wren_2;
  logic [AB-1:0] mem_addr_1, mem_addr_2;
  logic [NB-1:0] mem_data_1, mem_data_2;
  logic [NB-1:0] mem_q_1 = '0;
  logic [NB-1:0] mem_q_2 = '0;

  logic [NB-1:0] sram    [NW];
  logic [NB-1:0] ref_mem [NW];
  logic [N-1:0]    ex_rv_q = '0;
  logic [N*NB-1:0] ex_rd_q = '0;
  int m_rr = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.nreq(N), .nbits(NB), .nwords(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_grant  (req_grant),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mem_rden_1 (mem_rden_1),
    .mem_wren_1 (mem_wren_1),
    .mem_addr_1 (mem_addr_1),
    .mem_data_1 (mem_data_1),
    .mem_q_1    (mem_q_1),
    .mem_rden_2 (mem_rden_2),
    .mem_wren_2 (mem_wren_2),
    .mem_addr_2 (mem_addr_2),
    .mem_data_2 (mem_data_2),
    .mem_q_2    (mem_q_2)
  );

  // Dual-port SRAM with registered read: same-edge write leaves the read returning the old word
  always @(posedge clk) begin
    if (mem_rden_1) mem_q_1 <= sram[mem_addr_1];
    if (mem_rden_2) mem_q_2 <= sram[mem_addr_2];
    if (mem_wren_1) sram[mem_addr_1] <= mem_data_1;
    if (mem_wren_2) sram[mem_addr_2] <= mem_data_2;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [AB-1:0] ga(input int i);
    return req_addr[i*AB +: AB];
  endfunction

  function automatic logic [NB-1:0] gd(input int i);
    return req_data[i*NB +: NB];
  endfunction

  // Reference arbiter: cyclic search over requesters, shadow memory, one-cycle read return
  always @(negedge clk) begin : model
    int w1, w2, j;
    logic [N-1:0]    eg, nv;
    logic [N*NB-1:0] nd;
    logic [12:0]     e1, e2;
    w1 = -1; w2 = -1; eg = '0; e1 = '0; e2 = '0; nv = '0; nd = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (w1 < 0 && req_valid[j]) w1 = j;
      end
      if (w1 >= 0) begin
        for (int k = 1; k < N; k++) begin
          j = (w1 + k) % N;
          if (w2 < 0 && req_valid[j] && !(ga(j) == ga(w1) && (req_wr[j] || req_wr[w1]))) w2 = j;
        end
      end
    end
    if (w1 >= 0) begin
      eg[w1] = 1'b1;
      e1 = {~req_wr[w1], req_wr[w1], ga(w1), gd(w1)};
    end
    if (w2 >= 0) begin
      eg[w2] = 1'b1;
      e2 = {~req_wr[w2], req_wr[w2], ga(w2), gd(w2)};
    end
    check("grant", 64'(req_grant), 64'(eg));
    check("port1", 64'({mem_rden_1, mem_wren_1, mem_addr_1, mem_data_1}), 64'(e1));
    check("port2", 64'({mem_rden_2, mem_wren_2, mem_addr_2, mem_data_2}), 64'(e2));
    check("rsp_valid", 64'(rsp_valid), rst ? 64'd0 : 64'(ex_rv_q));
    check("rsp_data", 64'(rsp_data), rst ? 64'd0 : 64'(ex_rd_q));
    if (w1 >= 0 && !req_wr[w1]) begin nv[w1] = 1'b1; nd[w1*NB +: NB] = ref_mem[ga(w1)]; end
    if (w2 >= 0 && !req_wr[w2]) begin nv[w2] = 1'b1; nd[w2*NB +: NB] = ref_mem[ga(w2)]; end
    if (w1 >= 0 && req_wr[w1]) ref_mem[ga(w1)] = gd(w1);
    if (w2 >= 0 && req_wr[w2]) ref_mem[ga(w2)] = gd(w2);
    ex_rv_q = nv;
    ex_rd_q = nd;
    if (rst) m_rr = 0;
    else if (w2 >= 0) m_rr = (w2 + 1) % N;
    else if (w1 >= 0) m_rr = (w1 + 1) % N;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AB-1:0] a, input logic [NB-1:0] d);
    req_valid[i] = v;
    req_wr[i] = w;
    req_addr[i*AB +: AB] = a;
    req_data[i*NB +: NB] = d;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0;
    for (int a = 0; a < NW; a++) begin
      sram[a]    = NB'(8'h10 + a);
      ref_mem[a] = NB'(8'h10 + a);
    end
    sram[5] = 8'h3C;
    ref_mem[5] = 8'h3C;

    step(); req_valid = 4'hF; #2;
    check("reset_grant", 64'(req_grant), 64'd0);
    check("reset_rsp", 64'(rsp_valid), 64'd0);
    check("reset_en", 64'({mem_rden_1, mem_wren_1, mem_rden_2, mem_wren_2}), 64'd0);
    step();

    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AB'(i), NB'(8'h50 + i));
    #2; check("rr_c1_grant", 64'(req_grant), 64'b0011);
    step(); #2;
    check("rr_c2_grant", 64'(req_grant), 64'b1100);
    check("rr_c2_rsp", 64'(rsp_valid), 64'b0011);
    check("rr_c2_data", 64'(rsp_data), 64'h0000_1110);
    step(); #2;
    check("rr_c3_grant", 64'(req_grant), 64'b0011);
    check("rr_c3_rsp", 64'(rsp_valid), 64'b1100);
    check("rr_c3_data", 64'(rsp_data), 64'h1312_0000);
    step(); req_valid = '0; rst = 1'b1; #2;
    check("rst_kills_rsp", 64'(rsp_valid), 64'd0);
    step(); rst = 1'b0;

    set_req(0, 1'b1, 1'b1, 3'd3, 8'hA5);
    set_req(2, 1'b1, 1'b0, 3'd3, 8'h00);
    #2;
    check("wr_rd_grant", 64'(req_grant), 64'b0001);
    check("wr_rd_port2_idle", 64'({mem_rden_2, mem_wren_2}), 64'd0);
    step(); req_valid[0] = 1'b0; #2;
    check("rd_after_wr_grant", 64'(req_grant), 64'b0100);
    step(); req_valid = '0; #2;
    check("rd_after_wr_rsp", 64'(rsp_valid), 64'b0100);
    check("rd_after_wr_data", 64'(rsp_data), 64'h00A5_0000);

    step();
    set_req(1, 1'b1, 1'b0, 3'd5, 8'h00);
    set_req(3, 1'b1, 1'b0, 3'd5, 8'h00);
    #2; check("dual_rd_grant", 64'(req_grant), 64'b1010);
    step(); req_valid = '0; #2;
    check("dual_rd_rsp", 64'(rsp_valid), 64'b1010);
    check("dual_rd_data", 64'(rsp_data), 64'h3C00_3C00);

    step();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AB'(i), NB'(8'h60 + i));
    #2; check("pre_rst_grant", 64'(req_grant), 64'b1100);
    step(); rst = 1'b1; #2;
    check("in_rst_grant", 64'(req_grant), 64'd0);
    check("in_rst_rsp", 64'(rsp_valid), 64'd0);
    step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 3'd7, NB'(8'h70 + i));
    #2;
    check("post_rst_grant", 64'(req_grant), 64'b0001);
    check("post_rst_port2_idle", 64'({mem_rden_2, mem_wren_2}), 64'd0);
    step(); req_valid = '0; #2;
    check("post_rst_rsp", 64'(rsp_valid), 64'd0);

    step(); rst = 1'b1;
    step(); rst = 1'b0;
    set_req(2, 1'b1, 1'b0, 3'd7, 8'h00);
    for (int c = 0; c < 5; c++) begin
      #2;
      check("single_grant", 64'(req_grant), 64'b0100);
      check("single_port2_idle", 64'({mem_rden_2, mem_wren_2}), 64'd0);
      if (c > 0) begin
        check("single_rsp", 64'(rsp_valid), 64'b0100);
        check("single_data", 64'(rsp_data), 64'h0070_0000);
      end
      step();
    end
    req_valid = '0; #2;
    check("single_last_rsp", 64'(rsp_valid), 64'b0100);
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
